mult32_seq_ctrl: RTL and testbench

MULT32_SEQ_CTRL -- requirements
Module: mult32_seq_ctrl

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mul16_pipe.sv | 42 ++++
 rtl/mult32_seq_ctrl.sv | 97 +++++++++
 tb/tb_mult32_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier built
// from one pipelined 16x16 multiplier.
package mult_pkg;
  localparam int PP_W   = 16;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {SH_0, SH_16, SH_32} shift_t;

  // Issue order: k0 aL*bL, k1 aL*bH, k2 aH*bL, k3 aH*bH.
  function automatic shift_t shift_of(input logic [1:0] k);
    case (k)
      2'd0:    return SH_0;
      2'd3:    return SH_32;
      default: return SH_16;
    endcase
  endfunction

  function automatic logic [PROD_W-1:0] align_pp(input logic [2*PP_W-1:0] p,
                                                 input shift_t sh);
    case (sh)
      SH_0:    return {32'b0, p};
      SH_16:   return {16'b0, p, 16'b0};
      SH_32:   return {p, 32'b0};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/mul16_pipe.sv
// 16x16 unsigned multiplier, MUL_LAT register stages, with a valid/tag
// sideband that travels alongside each product.
module mul16_pipe
  import mult_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  shift_t            in_tag,
  input  logic [PP_W-1:0]   a,
  input  logic [PP_W-1:0]   b,
  output logic              out_vld,
  output shift_t            out_tag,
  output logic [2*PP_W-1:0] p
);
  logic [MUL_LAT:1]               vld_pipe;
  shift_t                         tag_pipe [1:MUL_LAT];
  logic [MUL_LAT:1][2*PP_W-1:0]   p_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      p_pipe   <= '0;
      for (int s = 1; s <= MUL_LAT; s++) tag_pipe[s] <= SH_0;
    end else begin
      vld_pipe[1] <= in_vld;
      tag_pipe[1] <= in_tag;
      p_pipe[1]   <= 32'(a) * 32'(b);
      for (int s = 2; s <= MUL_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
        p_pipe[s]   <= p_pipe[s-1];
      end
    end
  end

  assign out_vld = vld_pipe[MUL_LAT];
  assign out_tag = tag_pipe[MUL_LAT];
  assign p       = p_pipe[MUL_LAT];
endmodule

// File: rtl/mult32_seq_ctrl.sv
// 32x32 unsigned multiply controller: issues four 16x16 partials into a
// shared pipelined multiplier and accumulates the tagged, shifted results.
module mult32_seq_ctrl
  import mult_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);
  state_t            state, state_nxt;
  logic [OP_W-1:0]   a_q, b_q;
  logic [1:0]        k_q;
  logic [PROD_W-1:0] acc_q, prod_q, acc_sum;
  logic [PP_W-1:0]   mul_a, mul_b;
  logic              accept, iss_vld, res_vld, res_last;
  shift_t            res_tag;
  logic [2*PP_W-1:0] res_p;

  assign accept   = in_valid && (state == S_IDLE);
  assign iss_vld  = (state == S_ISSUE);
  assign mul_a    = k_q[1] ? a_q[OP_W-1:PP_W] : a_q[PP_W-1:0];
  assign mul_b    = k_q[0] ? b_q[OP_W-1:PP_W] : b_q[PP_W-1:0];
  assign acc_sum  = acc_q + align_pp(res_p, res_tag);
  // Only k3 carries the 32-bit shift, so it marks the final partial.
  assign res_last = res_vld && (res_tag == SH_32);

  mul16_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (iss_vld),
    .in_tag  (shift_of(k_q)),
    .a       (mul_a),
    .b       (mul_b),
    .out_vld (res_vld),
    .out_tag (res_tag),
    .p       (res_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (k_q == 2'd3) state_nxt = S_DRAIN;
      S_DRAIN: if (res_last) state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= op_a;
        b_q   <= op_b;
        k_q   <= '0;
        acc_q <= '0;
      end else begin
        if (iss_vld) k_q <= k_q + 2'd1;
        if (res_vld) acc_q <= acc_sum;
      end
      // product is a separate register so it holds across the next accept.
      if (state == S_DRAIN && res_last) prod_q <= acc_sum;
    end
  end

  assign product = prod_q;
endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Scoreboard bench for mult32_seq_ctrl: directed vectors, hold, reset abort,
// random stream, plus latency checks on MUL_LAT=2 and 3 instances.
module tb_mult32_seq_ctrl;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  logic        busy;

  logic        aux_iv = 1'b0;
  logic [31:0] aux_a = '0, aux_b = '0;
  logic [1:0]  aux_ir, aux_ov, aux_busy;
  logic [63:0] aux_prod [2];

  always #5 clk = ~clk;

  mult32_seq_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy));

  mult32_seq_ctrl #(.MUL_LAT(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_iv), .in_ready(aux_ir[0]),
    .op_a(aux_a), .op_b(aux_b), .out_valid(aux_ov[0]), .out_ready(1'b1),
    .product(aux_prod[0]), .busy(aux_busy[0]));

  mult32_seq_ctrl #(.MUL_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_iv), .in_ready(aux_ir[1]),
    .op_a(aux_a), .op_b(aux_b), .out_valid(aux_ov[1]), .out_ready(1'b1),
    .product(aux_prod[1]), .busy(aux_busy[1]));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [63:0] exp_q [$];
  int          lat_q [$];
  logic        rnd_ready = 1'b0, ready_force = 1'b1;
  logic        ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready changes just after the edge so negedge sampling sees it stable.
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks latency on rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) fail("unexpected_out_valid");
        else chk("latency", 64'(cyc - lat_q.pop_front()), 64'(4 + LAT));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("spurious_product");
        else chk("product", product, exp_q.pop_front());
      end
      ov_prev = out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit track);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("drain_timeout");
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] a64, b64;
    int          aux_lat [2];
    logic [63:0] aux_got [2];
    int          t0, n;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);

    // First edge after release accepts on the MUL_LAT=2/3 instances.
    rst_n  = 1'b1;
    aux_iv = 1'b1;
    aux_a  = 32'hFFFF_FFFF;
    aux_b  = 32'hFFFF_FFFF;
    chk("aux_in_ready", aux_ir, 2'b11);
    t0 = cyc + 1;
    @(posedge clk);
    #1 aux_iv = 1'b0;
    aux_lat = '{-1, -1};
    aux_got = '{64'd0, 64'd0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++)
        if (aux_ov[j] && aux_lat[j] < 0) begin
          aux_lat[j] = cyc - t0;
          aux_got[j] = aux_prod[j];
        end
    end
    chk("lat2_latency", 64'(aux_lat[0]), 64'd6);
    chk("lat2_product", aux_got[0], 64'hFFFF_FFFE_0000_0001);
    chk("lat3_latency", 64'(aux_lat[1]), 64'd7);
    chk("lat3_product", aux_got[1], 64'hFFFF_FFFE_0000_0001);

    // Directed vectors.
    issue(32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1); wait_drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1); wait_drain();
    issue(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1); wait_drain();
    issue(32'h1234_5678, 32'h0000_0000, 64'h0, 1); wait_drain();
    issue(32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001, 1); wait_drain();

    // Consumer stalls in DONE; result must hold and no new accept happens.
    ready_force = 1'b0;
    issue(32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("hold_wait_timeout");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_product", product, 64'h0000_0000_0001_2340);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ready_force = 1'b1;
    wait_drain();

    // Reset in the k=2 issue cycle discards the operation.
    issue(32'hDEAD_BEEF, 32'hCAFE_F00D, 64'h0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    chk("abort_in_ready", in_ready, 1);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd7, 32'd6, 64'h0000_0000_0000_002A, 1);
    wait_drain();

    // Random stream against a 64-bit reference product.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'h0;
        default: rb = $urandom;
      endcase
      a64 = {32'b0, ra};
      b64 = {32'b0, rb};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb, a64 * b64, 1);
    end
    wait_drain();
    rnd_ready = 1'b0;
    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) fail("scoreboard_not_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
